// File: rtl/acc_batch_ctrl.sv
// Batch controller: launches the engine until BATCH results are in the FIFO, then
// hands them to the consumer one per read edge, with optional overlapped drain and a watchdog.
module acc_batch_ctrl #(
    parameter int BATCH   = 8,
    parameter int CNT_W   = 4,
    parameter int OVERLAP = 0,
    parameter int TMO     = 255,
    parameter int TMO_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             eng_done,
    input  logic             full,
    input  logic             empty,
    input  logic             read,
    output logic             eng_start,
    output logic             wr_req,
    output logic             rd_req,
    output logic             rst_fifo,
    output logic             busy,
    output logic             finished,
    output logic             err_timeout,
    output logic [CNT_W-1:0] level
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LAUNCH,
        S_CALC,
        S_STORE,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);
    localparam logic [TMO_W-1:0] TMO_C   = TMO_W'(TMO);
    localparam bit               OVL     = (OVERLAP != 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [TMO_W-1:0]   r_timer;
    logic               r_read_q;
    logic               r_err;

    logic               w_read_rise;
    logic               w_rd_window;
    logic               w_tmo_hit;
    logic [TMO_W-1:0]   w_timer_inc;
    logic [CNT_W-1:0]   w_wr_next;
    logic [CNT_W-1:0]   w_rd_next;

    // Reads are legal only while draining, or while computing too when overlap is enabled.
    always_comb begin
        w_rd_window = 1'b0;
        if (r_state == S_DRAIN) begin
            w_rd_window = 1'b1;
        end else if (OVL && (r_state inside {S_LAUNCH, S_CALC, S_STORE})) begin
            w_rd_window = 1'b1;
        end
    end

    assign w_read_rise = read & ~r_read_q;
    assign wr_req      = (r_state == S_CALC) & eng_done & ~full & ~abort;
    assign rd_req      = w_rd_window & w_read_rise & ~empty & ~abort;
    assign w_wr_next   = r_wr_cnt + {{(CNT_W-1){1'b0}}, wr_req};
    assign w_rd_next   = r_rd_cnt + {{(CNT_W-1){1'b0}}, rd_req};
    assign w_timer_inc = r_timer + TMO_W'(1);
    assign w_tmo_hit   = (TMO != 0) && (w_timer_inc == TMO_C);

    assign eng_start   = (r_state == S_LAUNCH);
    assign rst_fifo    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign finished    = (r_state == S_DONE);
    assign err_timeout = r_err;
    assign level       = r_wr_cnt - r_rd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_timer  <= '0;
            r_read_q <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_read_q <= read;
            r_wr_cnt <= w_wr_next;
            r_rd_cnt <= w_rd_next;
            if (abort) begin
                r_state  <= S_IDLE;
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
                r_timer  <= '0;
                r_err    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_wr_cnt <= '0;
                        r_rd_cnt <= '0;
                        r_err    <= 1'b0;
                        if (start) r_state <= S_ARM;
                    end
                    // Launch on release of start so a held button does not re-trigger.
                    S_ARM: begin
                        if (!start) r_state <= S_LAUNCH;
                    end
                    S_LAUNCH: begin
                        r_timer <= '0;
                        r_state <= S_CALC;
                    end
                    S_CALC: begin
                        r_timer <= w_timer_inc;
                        if (eng_done) begin
                            r_state <= full ? S_DRAIN : S_STORE;
                        end else if (w_tmo_hit) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    S_STORE: begin
                        if (r_wr_cnt == BATCH_C || full) r_state <= S_DRAIN;
                        else                              r_state <= S_LAUNCH;
                    end
                    S_DRAIN: begin
                        if (w_rd_next == r_wr_cnt) r_state <= S_DONE;
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    S_ERR: begin
                        if (start) begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acc_batch_ctrl.sv
// Directed bench for acc_batch_ctrl: one non-overlapped instance (BATCH=3, TMO=10)
// and one overlapped instance (BATCH=4, no watchdog), each with a 4-cycle engine model.
module tb_acc_batch_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       aStart, aAbort, aEngDone, aFull, aEmpty, aRead;
    logic       aEngStart, aWrReq, aRdReq, aRstFifo, aBusy, aFinished, aErr;
    logic [3:0] aLevel;
    logic       bStart, bAbort, bEngDone, bFull, bEmpty, bRead;
    logic       bEngStart, bWrReq, bRdReq, bRstFifo, bBusy, bFinished, bErr;
    logic [3:0] bLevel;

    bit aEngOn;
    int aEngPending, bEngPending;
    int aStarts, aWrites, aReads, aFins;
    int bStarts, bWrites, bReads, bFins, bMaxLevel;
    int testsRun = 0;
    int testsFailed = 0;

    acc_batch_ctrl #(.BATCH(3), .CNT_W(4), .OVERLAP(0), .TMO(10), .TMO_W(8)) dutA (
        .clk(clk), .rst(rst), .start(aStart), .abort(aAbort), .eng_done(aEngDone),
        .full(aFull), .empty(aEmpty), .read(aRead), .eng_start(aEngStart),
        .wr_req(aWrReq), .rd_req(aRdReq), .rst_fifo(aRstFifo), .busy(aBusy),
        .finished(aFinished), .err_timeout(aErr), .level(aLevel)
    );

    acc_batch_ctrl #(.BATCH(4), .CNT_W(4), .OVERLAP(1), .TMO(0), .TMO_W(8)) dutB (
        .clk(clk), .rst(rst), .start(bStart), .abort(bAbort), .eng_done(bEngDone),
        .full(bFull), .empty(bEmpty), .read(bRead), .eng_start(bEngStart),
        .wr_req(bWrReq), .rd_req(bRdReq), .rst_fifo(bRstFifo), .busy(bBusy),
        .finished(bFinished), .err_timeout(bErr), .level(bLevel)
    );

    // Engine models: eng_done pulses four cycles after each launch pulse.
    initial begin
        aEngDone = 1'b0;
        aEngPending = 0;
        forever begin
            @(negedge clk);
            aEngDone = 1'b0;
            if (aEngPending > 0) begin
                aEngPending--;
                if (aEngPending == 0) aEngDone = 1'b1;
            end
            if (aEngStart && aEngOn) aEngPending = 4;
        end
    end

    initial begin
        bEngDone = 1'b0;
        bEngPending = 0;
        forever begin
            @(negedge clk);
            bEngDone = 1'b0;
            if (bEngPending > 0) begin
                bEngPending--;
                if (bEngPending == 0) bEngDone = 1'b1;
            end
            if (bEngStart) bEngPending = 4;
        end
    end

    // Pulse counters sampled well inside the low clock phase.
    initial begin
        aStarts = 0; aWrites = 0; aReads = 0; aFins = 0;
        bStarts = 0; bWrites = 0; bReads = 0; bFins = 0; bMaxLevel = 0;
        forever begin
            @(negedge clk);
            #3;
            if (aEngStart === 1'b1) aStarts++;
            if (aWrReq === 1'b1)    aWrites++;
            if (aRdReq === 1'b1)    aReads++;
            if (aFinished === 1'b1) aFins++;
            if (bEngStart === 1'b1) bStarts++;
            if (bWrReq === 1'b1)    bWrites++;
            if (bRdReq === 1'b1)    bReads++;
            if (bFinished === 1'b1) bFins++;
            if (int'(bLevel) > bMaxLevel) bMaxLevel = int'(bLevel);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitWrites(input bit useB, input int target, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((useB ? bWrites : aWrites) >= target) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(ok), 32'd1);
    endtask

    task automatic pulseReadA();
        aRead = 1'b1;
        @(negedge clk);
        aRead = 1'b0;
        @(negedge clk);
    endtask

    task automatic startBatchA();
        aStart = 1'b1;
        @(negedge clk);
        aStart = 1'b0;
    endtask

    initial begin
        int base;
        int fBase;
        int sBase;
        int rBase;
        bit seen;
        rst = 1'b1;
        aStart = 0; aAbort = 0; aFull = 0; aEmpty = 0; aRead = 0; aEngOn = 1'b1;
        bStart = 0; bAbort = 0; bFull = 0; bEmpty = 0; bRead = 0;
        applyStimulus(2);

        checkOutput("rstFifoA", 32'(aRstFifo), 32'd1);
        checkOutput("rstBusyA", 32'(aBusy), 32'd0);
        checkOutput("rstLevelA", 32'(aLevel), 32'd0);
        checkOutput("rstEngStartA", 32'(aEngStart), 32'd0);
        checkOutput("rstWrReqA", 32'(aWrReq), 32'd0);
        checkOutput("rstRdReqA", 32'(aRdReq), 32'd0);
        checkOutput("rstFinA", 32'(aFinished), 32'd0);
        checkOutput("rstErrA", 32'(aErr), 32'd0);
        checkOutput("rstFifoB", 32'(bRstFifo), 32'd1);
        rst = 1'b0;
        applyStimulus(1);

        // Plain batch of three, launched on release of start.
        aStart = 1'b1;
        @(negedge clk);
        checkOutput("armBusy", 32'(aBusy), 32'd1);
        checkOutput("armNoLaunch", 32'(aEngStart), 32'd0);
        aStart = 1'b0;
        waitWrites(1'b0, 3, "waitThreeWrites");
        applyStimulus(2);
        checkOutput("batchStarts", 32'(aStarts), 32'd3);
        checkOutput("batchWrites", 32'(aWrites), 32'd3);
        checkOutput("batchLevel", 32'(aLevel), 32'd3);
        checkOutput("drainBusy", 32'(aBusy), 32'd1);
        checkOutput("drainRstFifo", 32'(aRstFifo), 32'd0);
        checkOutput("noEarlyReads", 32'(aReads), 32'd0);

        aRead = 1'b1;
        applyStimulus(5);
        aRead = 1'b0;
        applyStimulus(1);
        checkOutput("heldReadOnce", 32'(aReads), 32'd1);
        checkOutput("levelAfterHeld", 32'(aLevel), 32'd2);

        aEmpty = 1'b1;
        aRead = 1'b1;
        @(negedge clk);
        aRead = 1'b0;
        aEmpty = 1'b0;
        @(negedge clk);
        checkOutput("emptyReadDropped", 32'(aReads), 32'd1);
        checkOutput("emptyLevelKept", 32'(aLevel), 32'd2);

        pulseReadA();
        pulseReadA();
        applyStimulus(2);
        checkOutput("allReads", 32'(aReads), 32'd3);
        checkOutput("oneFinished", 32'(aFins), 32'd1);
        checkOutput("idleBusy", 32'(aBusy), 32'd0);
        checkOutput("idleLevel", 32'(aLevel), 32'd0);
        checkOutput("idleRstFifo", 32'(aRstFifo), 32'd1);

        // FIFO full after the second write closes the batch early.
        sBase = aStarts; base = aWrites; rBase = aReads; fBase = aFins;
        startBatchA();
        waitWrites(1'b0, base + 2, "waitTwoWrites");
        aFull = 1'b1;
        applyStimulus(8);
        checkOutput("fullStarts", 32'(aStarts - sBase), 32'd2);
        checkOutput("fullLevel", 32'(aLevel), 32'd2);
        checkOutput("fullBusy", 32'(aBusy), 32'd1);
        aFull = 1'b0;
        pulseReadA();
        pulseReadA();
        applyStimulus(3);
        checkOutput("fullReads", 32'(aReads - rBase), 32'd2);
        checkOutput("fullFinished", 32'(aFins - fBase), 32'd1);
        checkOutput("fullIdle", 32'(aBusy), 32'd0);

        // Watchdog: silent engine, TMO=10.
        aEngOn = 1'b0;
        base = aWrites;
        startBatchA();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (aEngStart === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("tmoLaunchSeen", 32'(seen), 32'd1);
        applyStimulus(10);
        checkOutput("errNotYet", 32'(aErr), 32'd0);
        applyStimulus(1);
        checkOutput("errAtEleven", 32'(aErr), 32'd1);
        applyStimulus(3);
        checkOutput("errSticky", 32'(aErr), 32'd1);
        checkOutput("errBusy", 32'(aBusy), 32'd1);
        checkOutput("errNoWrite", 32'(aWrites - base), 32'd0);
        aStart = 1'b1;
        @(negedge clk);
        checkOutput("errCleared", 32'(aErr), 32'd0);
        checkOutput("errToIdle", 32'(aBusy), 32'd0);
        checkOutput("errRstFifo", 32'(aRstFifo), 32'd1);
        aStart = 1'b0;
        applyStimulus(1);

        // Abort while computing the second result.
        aEngOn = 1'b1;
        base = aWrites; fBase = aFins;
        startBatchA();
        waitWrites(1'b0, base + 1, "waitAbortWrite");
        applyStimulus(2);
        checkOutput("levelBeforeAbort", 32'(aLevel), 32'd1);
        aAbort = 1'b1;
        @(negedge clk);
        aAbort = 1'b0;
        checkOutput("abortIdle", 32'(aBusy), 32'd0);
        checkOutput("abortRstFifo", 32'(aRstFifo), 32'd1);
        checkOutput("abortLevel", 32'(aLevel), 32'd0);
        applyStimulus(8);
        checkOutput("abortNoFinish", 32'(aFins - fBase), 32'd0);
        checkOutput("abortOneWrite", 32'(aWrites - base), 32'd1);

        // Asynchronous reset in the middle of draining.
        base = aWrites;
        startBatchA();
        waitWrites(1'b0, base + 3, "waitRstWrites");
        applyStimulus(3);
        checkOutput("levelBeforeRst", 32'(aLevel), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstMidBusy", 32'(aBusy), 32'd0);
        checkOutput("rstMidLevel", 32'(aLevel), 32'd0);
        checkOutput("rstMidFifo", 32'(aRstFifo), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1);
        checkOutput("rstReleasedIdle", 32'(aBusy), 32'd0);

        // Overlapped drain on instance B.
        bStart = 1'b1;
        @(negedge clk);
        bStart = 1'b0;
        waitWrites(1'b1, 1, "waitB1");
        bRead = 1'b1;
        @(negedge clk);
        bRead = 1'b0;
        checkOutput("ovlFirstRead", 32'(bReads), 32'd1);
        checkOutput("ovlLevelZero", 32'(bLevel), 32'd0);

        waitWrites(1'b1, 2, "waitB2");
        applyStimulus(5);
        checkOutput("levelBeforeCoincide", 32'(bLevel), 32'd1);
        bRead = 1'b1;
        #1;
        checkOutput("coincideWr", 32'(bWrReq), 32'd1);
        checkOutput("coincideRd", 32'(bRdReq), 32'd1);
        @(negedge clk);
        bRead = 1'b0;
        checkOutput("coincideLevel", 32'(bLevel), 32'd1);
        checkOutput("coincideWrites", 32'(bWrites), 32'd3);
        checkOutput("coincideReads", 32'(bReads), 32'd2);
        @(negedge clk);
        bRead = 1'b1;
        @(negedge clk);
        bRead = 1'b0;
        checkOutput("ovlThirdRead", 32'(bReads), 32'd3);

        waitWrites(1'b1, 4, "waitB4");
        bRead = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        bRead = 1'b0;
        seen = seen | bFinished;
        @(negedge clk);
        seen = seen | bFinished;
        checkOutput("ovlFinishWithin2", 32'(seen), 32'd1);
        applyStimulus(2);
        checkOutput("ovlFinOnce", 32'(bFins), 32'd1);
        checkOutput("ovlStarts", 32'(bStarts), 32'd4);
        checkOutput("ovlReads", 32'(bReads), 32'd4);
        checkOutput("ovlMaxLevel", 32'(bMaxLevel), 32'd1);
        checkOutput("ovlIdle", 32'(bBusy), 32'd0);
        checkOutput("ovlNoErr", 32'(bErr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
